dmem_bytelane: RTL and testbench

Parametrised data memory for the MEM stage of the 5-stage pipeline.
- Byte-addressed and big-endian: byte offset 0 maps to bits [31:24].
- Supports byte, halfword and word loads (signed or unsigned) and byte, halfword and word stores with lane steering.
- Flags misaligned and out-of-range accesses.
- After reset, a sequencer self-initialises the array one word per cycle, replacing bulk clearing of the array.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_lane_align.sv | 45 ++++
 rtl/dmem_bytelane.sv | 109 ++++++++++
 tb/tb_dmem_bytelane.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes, sequencer
// states and big-endian lane helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic {INIT, IDLE} state_t;

  // Byte-enable bit 3 is lane [31:24], i.e. byte offset 0 (big-endian).
  localparam logic [3:0] BE_BYTE0 = 4'b1000;
  localparam logic [3:0] BE_HALF0 = 4'b1100;
  localparam logic [3:0] BE_HALF2 = 4'b0011;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  // Right-shift that brings byte offset k down to bits [7:0]: 8*(3-k).
  function automatic logic [4:0] lane_shift(input logic [1:0] offset);
    return {~offset, 3'b000};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables/data replication and
// load extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be     = '0;
    wlane  = '0;
    rdata  = '0;
    byte_v = 8'(rword >> lane_shift(offset));
    half_v = offset[1] ? rword[15:0] : rword[31:16];
    case (size)
      SZ_BYTE: begin
        be    = BE_BYTE0 >> offset;
        wlane = {4{wdata[7:0]}};
        rdata = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        be    = offset[1] ? BE_HALF2 : BE_HALF0;
        wlane = {2{wdata[15:0]}};
        rdata = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      end
      SZ_WORD: begin
        be    = BE_WORD;
        wlane = wdata;
        rdata = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Big-endian byte-addressed data memory for the MEM stage with fault
// detection and a post-reset init sequencer that writes one word per cycle.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W      = 32,
  parameter logic [31:0] INIT0       = 32'd9,
  parameter logic [31:0] INIT1       = 32'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [31:0]       ReadData,
  output logic              rd_valid,
  output logic              err,
  output logic              busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t            state, state_next;
  logic [AW-1:0]     ptr;
  logic [31:0]       mem [DEPTH_WORDS];

  logic [AW-1:0]     idx;
  logic [1:0]        offset;
  logic [ADDR_W-1:0] hi_bits;
  logic              out_of_range, misaligned, illegal, fault;
  logic              accept, init_we, st_we, init_last;
  logic [31:0]       init_val, rword, wlane, rdata;
  logic [3:0]        be;

  assign idx          = address[AW+1:2];
  assign offset       = address[1:0];
  assign hi_bits      = address >> (AW + 2);
  assign out_of_range = |hi_bits;
  assign misaligned   = ((size == SZ_HALF) && address[0]) ||
                        ((size == SZ_WORD) && (address[1:0] != 2'b00));
  assign illegal      = (size == SZ_ILLEGAL);
  assign fault        = out_of_range | misaligned | illegal;
  assign init_last    = (ptr == AW'(DEPTH_WORDS - 1));
  assign rword        = mem[idx];

  dmem_lane_align u_align (
    .size        (size),
    .offset      (offset),
    .is_unsigned (is_unsigned),
    .wdata       (WriteData),
    .rword       (rword),
    .be          (be),
    .wlane       (wlane),
    .rdata       (rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == INIT && init_last) state_next = IDLE;
  end

  always_comb begin
    busy     = (state == INIT);
    accept   = (state == IDLE);
    init_we  = (state == INIT) && reset;
    st_we    = accept && MemWrite && !fault;
    init_val = '0;
    if (ptr == AW'(0))      init_val = INIT0;
    else if (ptr == AW'(1)) init_val = INIT1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              ptr <= '0;
    else if (state == INIT)  ptr <= ptr + 1'b1;
  end

  // Array has no reset; contents are rebuilt by the sequencer instead.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[ptr] <= init_val;
    end else if (st_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadData <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= accept && MemRead;
      err      <= accept && (MemRead || MemWrite) && fault;
      if (accept && MemRead) ReadData <= fault ? '0 : rdata;
    end
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench for dmem_bytelane: each request pushes its expected
// response, a negedge monitor pops and compares when it falls due.
module tb_dmem_bytelane;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] WriteData;
  logic        MemRead, MemWrite;
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] ReadData;
  logic        rd_valid, err, busy;

  typedef struct {
    string       tag;
    logic        rv;
    logic        er;
    logic [31:0] d;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic        mon_en = 1'b0;
  logic [31:0] last_data = '0;
  int unsigned cnt;

  dmem_bytelane #(
    .DEPTH_WORDS (64),
    .ADDR_W      (32),
    .INIT0       (32'd9),
    .INIT1       (32'd1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .WriteData   (WriteData),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .size        (size),
    .is_unsigned (is_unsigned),
    .ReadData    (ReadData),
    .rd_valid    (rd_valid),
    .err         (err),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request for one cycle; called just after a rising edge.
  task automatic acc(input string tag, input logic rd, input logic wr,
                     input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic erv, input logic eerr, input logic [31:0] ed);
    exp_t e;
    address = a; WriteData = wd; size = sz; is_unsigned = uns;
    MemRead = rd; MemWrite = wr;
    e.tag = tag; e.rv = erv; e.er = eerr; e.d = ed; e.due = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic wait_init(output int unsigned n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, ".rd_valid"}, 32'(rd_valid), 32'(e.rv));
        check({e.tag, ".err"}, 32'(err), 32'(e.er));
        if (e.rv) last_data = e.d;
        check({e.tag, ".data"}, ReadData, last_data);
      end else begin
        check("idle.rd_valid", 32'(rd_valid), 32'd0);
        check("idle.err", 32'(err), 32'd0);
        check("idle.hold", ReadData, last_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; address = '0; WriteData = '0; MemRead = 1'b0; MemWrite = 1'b0;
    size = SZ_WORD; is_unsigned = 1'b0;
    #2;
    check("rst.ReadData", ReadData, 32'd0);
    check("rst.rd_valid", 32'(rd_valid), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    wait_init(cnt);
    check("init.busy_cycles", cnt, 32'd64);
    last_data = '0;
    mon_en = 1'b1;

    acc("lw0",  1, 0, SZ_WORD, 0, 32'h00, '0, 1, 0, 32'h00000009);
    acc("lw4",  1, 0, SZ_WORD, 0, 32'h04, '0, 1, 0, 32'h00000001);
    acc("lw8",  1, 0, SZ_WORD, 0, 32'h08, '0, 1, 0, 32'h00000000);
    acc("lwFC", 1, 0, SZ_WORD, 0, 32'hFC, '0, 1, 0, 32'h00000000);

    acc("sw10", 0, 1, SZ_WORD, 0, 32'h10, 32'h11223344, 0, 0, '0);
    acc("sb11", 0, 1, SZ_BYTE, 0, 32'h11, 32'h000000AB, 0, 0, '0);
    acc("lw10", 1, 0, SZ_WORD, 0, 32'h10, '0, 1, 0, 32'h11AB3344);
    acc("lb11", 1, 0, SZ_BYTE, 0, 32'h11, '0, 1, 0, 32'hFFFFFFAB);
    acc("lbu11",1, 0, SZ_BYTE, 1, 32'h11, '0, 1, 0, 32'h000000AB);
    acc("lb10", 1, 0, SZ_BYTE, 0, 32'h10, '0, 1, 0, 32'h00000011);
    acc("lb13", 1, 0, SZ_BYTE, 0, 32'h13, '0, 1, 0, 32'h00000044);

    acc("sh22", 0, 1, SZ_HALF, 0, 32'h22, 32'h00008001, 0, 0, '0);
    acc("lh22", 1, 0, SZ_HALF, 0, 32'h22, '0, 1, 0, 32'hFFFF8001);
    acc("lhu22",1, 0, SZ_HALF, 1, 32'h22, '0, 1, 0, 32'h00008001);
    acc("lw20", 1, 0, SZ_WORD, 0, 32'h20, '0, 1, 0, 32'h00008001);
    acc("lh20", 1, 0, SZ_HALF, 0, 32'h20, '0, 1, 0, 32'h00000000);

    acc("lw13_mis",  1, 0, SZ_WORD,    0, 32'h13,  '0, 1, 1, 32'h00000000);
    acc("sh15_mis",  0, 1, SZ_HALF,    0, 32'h15,  32'h0000FFFF, 0, 1, '0);
    acc("s11_ill",   0, 1, SZ_ILLEGAL, 0, 32'h14,  32'hFFFFFFFF, 0, 1, '0);
    acc("lw14",      1, 0, SZ_WORD,    0, 32'h14,  '0, 1, 0, 32'h00000000);
    acc("sw100_oor", 0, 1, SZ_WORD,    0, 32'h100, 32'h12345678, 0, 1, '0);
    acc("lw100_oor", 1, 0, SZ_WORD,    0, 32'h100, '0, 1, 1, 32'h00000000);
    acc("lw0_after", 1, 0, SZ_WORD,    0, 32'h00,  '0, 1, 0, 32'h00000009);

    acc("sw30",    0, 1, SZ_WORD, 0, 32'h30, 32'h5, 0, 0, '0);
    acc("rw30",    1, 1, SZ_WORD, 0, 32'h30, 32'h7, 1, 0, 32'h00000005);
    acc("lw30",    1, 0, SZ_WORD, 0, 32'h30, '0, 1, 0, 32'h00000007);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    mon_en = 1'b0;

    // Reset while a load result is on the outputs.
    address = 32'h10; size = SZ_WORD; is_unsigned = 1'b0; MemRead = 1'b1;
    @(posedge clk); #1;
    MemRead = 1'b0;
    check("pre_rst.rd_valid", 32'(rd_valid), 32'd1);
    check("pre_rst.data", ReadData, 32'h11AB3344);
    reset = 1'b0;
    #1;
    check("mid_rst.rd_valid", 32'(rd_valid), 32'd0);
    check("mid_rst.ReadData", ReadData, 32'd0);
    check("mid_rst.busy", 32'(busy), 32'd1);

    @(posedge clk); #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("init10.busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("init10_rst.busy", 32'(busy), 32'd1);
    check("init10_rst.rd_valid", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    last_data = '0;
    mon_en = 1'b1;

    address = 32'h0; size = SZ_WORD; WriteData = 32'hDEADBEEF;
    MemRead = 1'b1; MemWrite = 1'b1;
    wait_init(cnt);
    MemRead = 1'b0; MemWrite = 1'b0;
    check("reinit.busy_cycles", cnt, 32'd64);

    acc("re_lw0",  1, 0, SZ_WORD, 0, 32'h00, '0, 1, 0, 32'h00000009);
    acc("re_lw4",  1, 0, SZ_WORD, 0, 32'h04, '0, 1, 0, 32'h00000001);
    acc("re_lw10", 1, 0, SZ_WORD, 0, 32'h10, '0, 1, 0, 32'h00000000);
    acc("re_lw30", 1, 0, SZ_WORD, 0, 32'h30, '0, 1, 0, 32'h00000000);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained_end", sb.size(), 32'd0);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
